// File: rtl/spike_rate_decoder.sv
// Counts spikes over WINDOW enabled cycles and tracks the latest inter-spike interval (ISI).
// rate/rate_valid update on the edge that samples the last window cycle; unconsumed data is overwritten and overrun is set.
module spike_rate_decoder #(
    parameter int WINDOW = 256,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          spike,
    input  logic          clear,
    output logic [CW-1:0] rate,
    output logic          rate_valid,
    input  logic          rate_ready,
    output logic          overrun,
    output logic [7:0]    isi
);

    localparam int            WW    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] CMAX  = '1;

    logic [WW-1:0] wcnt;
    logic [CW-1:0] cnt;
    logic [7:0]    g;

    logic          last_cycle;
    logic          done;
    logic          xfer;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    g_inc;

    assign last_cycle = (wcnt == WLAST);
    assign done       = en && last_cycle;
    assign xfer       = rate_valid && rate_ready;

    // Saturating next values; cnt_inc also folds in a spike on the closing cycle.
    assign cnt_inc = (spike && (cnt != CMAX)) ? cnt + 1'b1 : cnt;
    assign g_inc   = (g != 8'hFF) ? g + 8'd1 : g;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
            cnt  <= '0;
            g    <= '0;
            isi  <= '0;
        end else if (clear) begin
            wcnt <= '0;
            cnt  <= '0;
            g    <= '0;
            isi  <= '0;
        end else if (en) begin
            if (last_cycle) begin
                wcnt <= '0;
                cnt  <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                cnt  <= cnt_inc;
            end
            if (spike) begin
                isi <= g_inc;
                g   <= '0;
            end else begin
                g <= g_inc;
            end
        end
    end

    // A completion always wins over a transfer on the same edge; overrun only when nobody took the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            rate       <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            rate       <= cnt_inc;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) begin
                overrun <= 1'b1;
            end
        end else if (xfer) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: three parameterisations share one stimulus set.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    logic rst, en, spike, clear, rate_ready;

    logic [7:0] rate16, isi16;
    logic       v16, o16;
    logic [3:0] rate32;
    logic [7:0] isi32;
    logic       v32, o32;
    logic [7:0] rate8, isi8;
    logic       v8, o8;

    int total = 0;
    int bad   = 0;

    logic [7:0] q16[$];
    logic [7:0] q32[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW(16), .CW(8)) d16 (
        .clk(clk), .rst(rst), .en(en), .spike(spike), .clear(clear),
        .rate(rate16), .rate_valid(v16), .rate_ready(rate_ready),
        .overrun(o16), .isi(isi16));

    spike_rate_decoder #(.WINDOW(32), .CW(4)) d32 (
        .clk(clk), .rst(rst), .en(en), .spike(spike), .clear(clear),
        .rate(rate32), .rate_valid(v32), .rate_ready(rate_ready),
        .overrun(o32), .isi(isi32));

    spike_rate_decoder #(.WINDOW(8), .CW(8)) d8 (
        .clk(clk), .rst(rst), .en(en), .spike(spike), .clear(clear),
        .rate(rate8), .rate_valid(v8), .rate_ready(rate_ready),
        .overrun(o8), .isi(isi8));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; spike = 1'b0; clear = 1'b0; rate_ready = 1'b0;
        q16.delete(); q32.delete(); q8.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; spike = 1'b0; clear = 1'b0; rate_ready = 1'b0;
        @(negedge clk);
        total++; if (rate16 !== 8'd0) begin bad++; $display("FAIL reset_rate got=%0d want=0", rate16); end
        total++; if (v16 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", v16); end
        total++; if (o16 !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", o16); end
        total++; if (isi16 !== 8'd0) begin bad++; $display("FAIL reset_isi got=%0d want=0", isi16); end
        rst = 1'b0;
    endtask

    task automatic test_basic_rate();
        int n;
        logic [7:0] e;
        do_reset();
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            spike = (i % 4 == 0);
            if (spike) n++;
            if (i == 15) begin
                q16.push_back(8'(n));
                total++; if (v16 !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b want=0", v16); end
            end
            tick();
        end
        e = q16.pop_front();
        total++; if (v16 !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", v16); end
        total++; if (rate16 !== e) begin bad++; $display("FAIL basic_rate got=%0d want=%0d", rate16, e); end
        rate_ready = 1'b1; spike = 1'b0;
        tick();
        rate_ready = 1'b0;
        total++; if (v16 !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%0b want=0", v16); end
        q16.push_back(8'd1);
        for (int i = 1; i < 16; i++) begin
            spike = (i == 15);
            tick();
        end
        spike = 1'b0;
        e = q16.pop_front();
        total++; if (v16 !== 1'b1 || rate16 !== e) begin bad++; $display("FAIL basic_last_cycle got=%0b/%0d want=1/%0d", v16, rate16, e); end
    endtask

    task automatic test_saturation();
        logic [7:0] e;
        do_reset();
        en = 1'b1; spike = 1'b1;
        q32.push_back(8'd15);
        q16.push_back(8'd16);
        q16.push_back(8'd16);
        for (int i = 0; i < 32; i++) tick();
        spike = 1'b0; en = 1'b0;
        e = q32.pop_front();
        total++; if (v32 !== 1'b1 || rate32 !== e[3:0]) begin bad++; $display("FAIL sat_rate got=%0b/%0d want=1/%0d", v32, rate32, e); end
        total++; if (isi32 !== 8'd1) begin bad++; $display("FAIL sat_isi got=%0d want=1", isi32); end
        void'(q16.pop_front());
        e = q16.pop_front();
        total++; if (rate16 !== e || o16 !== 1'b1) begin bad++; $display("FAIL sat_w16 got=%0d/%0b want=%0d/1", rate16, o16, e); end
    endtask

    task automatic test_handshake();
        logic [7:0] e;
        do_reset();
        en = 1'b1; rate_ready = 1'b0;
        q16.push_back(8'd3);
        for (int i = 0; i < 16; i++) begin spike = (i < 3); tick(); end
        q16.push_back(8'd5);
        for (int i = 0; i < 16; i++) begin spike = (i < 5); tick(); end
        void'(q16.pop_front());
        e = q16.pop_front();
        total++; if (rate16 !== e) begin bad++; $display("FAIL hs_overwrite got=%0d want=%0d", rate16, e); end
        total++; if (v16 !== 1'b1 || o16 !== 1'b1) begin bad++; $display("FAIL hs_overrun got=%0b/%0b want=1/1", v16, o16); end
        clear = 1'b1; spike = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (o16 !== 1'b0 || v16 !== 1'b0 || isi16 !== 8'd0) begin bad++; $display("FAIL hs_clear got=%0b/%0b/%0d want=0/0/0", o16, v16, isi16); end
        q16.push_back(8'd2);
        for (int i = 0; i < 16; i++) begin spike = (i % 8 == 0); tick(); end
        e = q16.pop_front();
        total++; if (v16 !== 1'b1 || rate16 !== e || o16 !== 1'b0) begin bad++; $display("FAIL hs_after_clear got=%0b/%0d/%0b want=1/%0d/0", v16, rate16, o16, e); end
        q16.push_back(8'd6);
        for (int i = 0; i < 16; i++) begin
            spike = (i < 6);
            rate_ready = (i == 15);
            tick();
        end
        rate_ready = 1'b0;
        e = q16.pop_front();
        total++; if (v16 !== 1'b1 || rate16 !== e || o16 !== 1'b0) begin bad++; $display("FAIL hs_xfer_complete got=%0b/%0d/%0b want=1/%0d/0", v16, rate16, o16, e); end
        for (int i = 0; i < 16; i++) begin
            spike = (i < 4);
            clear = (i == 15);
            tick();
        end
        clear = 1'b0; spike = 1'b0;
        total++; if (v16 !== 1'b0 || rate16 !== 8'd0) begin bad++; $display("FAIL hs_clear_wins got=%0b/%0d want=0/0", v16, rate16); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 1);
            spike = !en;
            if (i == 15) begin
                q8.push_back(8'd0);
                total++; if (v8 !== 1'b0) begin bad++; $display("FAIL gate_early got=%0b want=0", v8); end
            end
            tick();
        end
        e = q8.pop_front();
        total++; if (v8 !== 1'b1 || rate8 !== e) begin bad++; $display("FAIL gate_rate got=%0b/%0d want=1/%0d", v8, rate8, e); end
        total++; if (isi8 !== 8'd0) begin bad++; $display("FAIL gate_isi_hold got=%0d want=0", isi8); end
        en = 1'b1; spike = 1'b1;
        tick();
        spike = 1'b0;
        total++; if (isi8 !== 8'd9) begin bad++; $display("FAIL gate_gap_frozen got=%0d want=9", isi8); end
    endtask

    task automatic test_isi();
        do_reset();
        en = 1'b1; rate_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            spike = (i == 3 || i == 10 || i == 20 || i == 21);
            tick();
            if (i == 3) begin
                total++; if (isi16 !== 8'd4) begin bad++; $display("FAIL isi_first got=%0d want=4", isi16); end
            end
            if (i == 10) begin
                total++; if (isi16 !== 8'd7) begin bad++; $display("FAIL isi_gap7 got=%0d want=7", isi16); end
            end
            if (i == 21) begin
                total++; if (isi16 !== 8'd1) begin bad++; $display("FAIL isi_back_to_back got=%0d want=1", isi16); end
            end
        end
        spike = 1'b0;
        for (int i = 0; i < 299; i++) tick();
        spike = 1'b1;
        tick();
        spike = 1'b0;
        total++; if (isi16 !== 8'd255) begin bad++; $display("FAIL isi_saturate got=%0d want=255", isi16); end
        rate_ready = 1'b0;
    endtask

    task automatic test_midwindow_reset();
        logic [7:0] e;
        do_reset();
        en = 1'b1;
        q16.push_back(8'd4);
        for (int i = 0; i < 16; i++) begin spike = (i % 5 == 0); tick(); end
        e = q16.pop_front();
        total++; if (v16 !== 1'b1 || rate16 !== e) begin bad++; $display("FAIL mid_pre got=%0b/%0d want=1/%0d", v16, rate16, e); end
        for (int i = 0; i < 7; i++) begin spike = (i < 3); tick(); end
        spike = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (rate16 !== 8'd0 || v16 !== 1'b0 || o16 !== 1'b0 || isi16 !== 8'd0) begin
            bad++; $display("FAIL mid_async got=%0d/%0b/%0b/%0d want=0/0/0/0", rate16, v16, o16, isi16);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                q16.push_back(8'd0);
                total++; if (v16 !== 1'b0) begin bad++; $display("FAIL mid_early got=%0b want=0", v16); end
            end
            tick();
        end
        e = q16.pop_front();
        total++; if (v16 !== 1'b1 || rate16 !== e) begin bad++; $display("FAIL mid_window got=%0b/%0d want=1/%0d", v16, rate16, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_rate();
        test_saturation();
        test_handshake();
        test_enable_gating();
        test_isi();
        test_midwindow_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
